// File: rtl/alu_dispatch_if.sv
// Operation encoding shared with the attached alu, and the instruction/writeback
// handshake bundle between the issue stage and its producer/consumer.
package alu_dispatch_pkg;
  typedef enum logic [2:0] {
    ALU_OP_ADD = 3'd0,
    ALU_OP_SUB = 3'd1,
    ALU_OP_AND = 3'd2,
    ALU_OP_OR  = 3'd3,
    ALU_OP_XOR = 3'd4,
    ALU_OP_NEG = 3'd5,
    ALU_OP_SLL = 3'd6,
    ALU_OP_SRL = 3'd7
  } alu_operation_e;
endpackage

interface alu_dispatch_if #(
    parameter int Width = 4,
    parameter int RegAw = 2
);
    import alu_dispatch_pkg::*;

    logic                 instr_valid_i;
    logic                 instr_ready_o;
    alu_operation_e       instr_op_i;
    logic [RegAw-1:0]     instr_rd_i;
    logic [RegAw-1:0]     instr_rs1_i;
    logic [RegAw-1:0]     instr_rs2_i;
    logic                 instr_use_imm_i;
    logic [Width-1:0]     instr_imm_i;

    logic                 wb_valid_o;
    logic                 wb_ready_i;
    logic [RegAw-1:0]     wb_rd_o;
    logic [Width-1:0]     wb_data_o;

    // master: instruction producer and writeback consumer
    modport master (
        output instr_valid_i, instr_op_i, instr_rd_i, instr_rs1_i, instr_rs2_i,
               instr_use_imm_i, instr_imm_i, wb_ready_i,
        input  instr_ready_o, wb_valid_o, wb_rd_o, wb_data_o
    );

    modport slave (
        input  instr_valid_i, instr_op_i, instr_rd_i, instr_rs1_i, instr_rs2_i,
               instr_use_imm_i, instr_imm_i, wb_ready_i,
        output instr_ready_o, wb_valid_o, wb_rd_o, wb_data_o
    );
endinterface

// File: rtl/alu_dispatch.sv
// Issue stage ahead of alu: instruction FIFO, register file, writeback register.
// ALU_DISPATCH_FORWARD_EN: forward wb_data_o on RAW hazards instead of stalling.
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int Width   = 4,
    parameter int NumRegs = 4,
    parameter int Depth   = 4,
    localparam int RegAw  = $clog2(NumRegs)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    alu_dispatch_if.slave     bus,
    output logic [Width-1:0]  alu_a_o,
    output logic [Width-1:0]  alu_b_o,
    output alu_operation_e    alu_op_o,
    input  logic [Width-1:0]  alu_result_i,
    input  logic [RegAw-1:0]  dbg_addr_i,
    output logic [Width-1:0]  dbg_data_o,
    output logic              busy_o
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    typedef struct packed {
        alu_operation_e   op;
        logic [RegAw-1:0] rd;
        logic [RegAw-1:0] rs1;
        logic [RegAw-1:0] rs2;
        logic             use_imm;
        logic [Width-1:0] imm;
    } instr_t;

    instr_t [Depth-1:0]            fifo_q;
    logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic                          rdy_q;
    logic [NumRegs-1:0][Width-1:0] regs_q;
    logic                          wb_valid_q, wb_valid_d;
    logic [RegAw-1:0]              wb_rd_q, wb_rd_d;
    logic [Width-1:0]              wb_data_q, wb_data_d;

    instr_t           head, in_instr;
    logic             empty, full, push, issue, wb_fire;
    logic             haz_a, haz_b, stall_haz;
    logic [Width-1:0] opa, opb_reg;

    assign head    = fifo_q[rd_ptr_q];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CntW'(Depth));
    assign push    = bus.instr_valid_i && bus.instr_ready_o;
    assign wb_fire = wb_valid_q && bus.wb_ready_i;

    assign in_instr = '{op:      bus.instr_op_i,
                        rd:      bus.instr_rd_i,
                        rs1:     bus.instr_rs1_i,
                        rs2:     bus.instr_rs2_i,
                        use_imm: bus.instr_use_imm_i,
                        imm:     bus.instr_imm_i};

    // rdy_q keeps ready low through reset and rises on the first edge after release
    assign bus.instr_ready_o = rdy_q && !full;

    assign haz_a = wb_valid_q && (wb_rd_q == head.rs1);
    assign haz_b = wb_valid_q && !head.use_imm && (wb_rd_q == head.rs2);

`ifdef ALU_DISPATCH_FORWARD_EN
    // wb_data_q is the value about to land in regs_q, so it is safe to use even as it commits
    assign opa       = haz_a ? wb_data_q : regs_q[head.rs1];
    assign opb_reg   = haz_b ? wb_data_q : regs_q[head.rs2];
    assign stall_haz = 1'b0;
`else
    assign opa       = regs_q[head.rs1];
    assign opb_reg   = regs_q[head.rs2];
    assign stall_haz = haz_a || haz_b;
`endif

    assign issue = !empty && (!wb_valid_q || bus.wb_ready_i) && !stall_haz;

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = ALU_OP_ADD;
        if (issue) begin
            alu_a_o  = opa;
            alu_b_o  = head.use_imm ? head.imm : opb_reg;
            alu_op_o = head.op;
        end
    end

    always_comb begin
        wr_ptr_d = push  ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = issue ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, issue})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (issue) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = head.rd;
            wb_data_d  = alu_result_i;
        end else if (wb_fire) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= 1'b1;
        end
    end

    // Payload needs no reset: an empty count makes stale entries unreachable
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= in_instr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
        end else if (wb_fire) begin
            regs_q[wb_rd_q] <= wb_data_q;
        end
    end

    assign bus.wb_valid_o = wb_valid_q;
    assign bus.wb_rd_o    = wb_rd_q;
    assign bus.wb_data_o  = wb_data_q;
    assign dbg_data_o     = regs_q[dbg_addr_i];
    assign busy_o         = !empty || wb_valid_q;
endmodule
